// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide UART TX path between NUM_REQ requesters.
// Optional source tag byte before each packet: define UART_TX_ARB_TAG_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no owner; pick next requester round-robin from rr_ptr_q
// ST_TAG    | (tag builds) presenting TAG_BASE + owner index on the line
// ST_STREAM | owner's bytes pass straight through until its last byte is accepted

module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 3,
    parameter logic [7:0] TAG_BASE = 8'hF0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int        IW        = $clog2(NUM_REQ);
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef UART_TX_ARB_TAG_EN
        ST_TAG    = 2'd1,
`endif
        ST_STREAM = 2'd2
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        idx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;

    logic                 found_d;
    logic [IW-1:0]        sel_idx_d;
    logic [IW:0]          sum;
    logic [IW-1:0]        cand;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;
    logic [IW-1:0]        rr_ptr_d;

    // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found_d   = 1'b0;
        sel_idx_d = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[IW-1:0];
            if (!found_d && req_valid_i[cand]) begin
                found_d   = 1'b1;
                sel_idx_d = cand;
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx_q == IW'(k)) begin
                own_valid = req_valid_i[k];
                own_last  = req_last_i[k];
                own_data  = req_data_i[k*8 +: 8];
            end
        end
    end

    assign rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

`ifdef UART_TX_ARB_TAG_EN
    logic [7:0] tag_byte;
    assign tag_byte = TAG_BASE + 8'(idx_q);
`else
    logic unused_tag_base;
    assign unused_tag_base = ^TAG_BASE;
`endif

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        case (state_q)
            ST_STREAM: begin
                tx_valid_o  = own_valid;
                tx_data_o   = own_valid ? own_data : 8'h00;
                req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
            end
`ifdef UART_TX_ARB_TAG_EN
            ST_TAG: begin
                tx_valid_o = 1'b1;
                tx_data_o  = tag_byte;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        idx_q   <= sel_idx_d;
                        grant_q <= NUM_REQ'(1) << sel_idx_d;
                        busy_q  <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        state_q <= ST_TAG;
`else
                        state_q <= ST_STREAM;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                ST_TAG: begin
                    if (tx_ready_i) begin
                        state_q <= ST_STREAM;
                    end
                end
`endif
                ST_STREAM: begin
                    // Grant is released only on an accepted last byte; a stalled owner holds the line.
                    if (own_valid && tx_ready_i && own_last) begin
                        rr_ptr_q <= rr_ptr_d;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=3); tag-byte checks run when UART_TX_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0] e_dat [11] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20, 8'h21, 8'h00, 8'h00};
    logic [2:0] e_g   [11] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    logic       t4_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t4_dat [5] = '{8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};
    int         bi [N];
    logic [N-1:0] rdy_seen;

    uart_tx_arbiter #(.NUM_REQ(N), .TAG_BASE(8'hF0)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic txv, input logic [7:0] txd,
                           input logic [N-1:0] rdy, input logic [N-1:0] g, input logic b);
        chk({tag, "_txv"},  32'(tx_valid),  32'(txv));
        chk({tag, "_txd"},  32'(tx_data),   32'(txd));
        chk({tag, "_rdy"},  32'(req_ready), 32'(rdy));
        chk({tag, "_gnt"},  32'(grant),     32'(g));
        chk({tag, "_busy"}, 32'(busy),      32'(b));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic setreq(input int k, input logic v, input logic [7:0] d, input logic l);
        req_valid[k]       = v;
        req_data[k*8 +: 8] = d;
        req_last[k]        = l;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;

`ifdef UART_TX_ARB_TAG_EN
        do_reset();
        setreq(2, 1'b1, 8'hA5, 1'b1);
        settle();
        chk_out("tag_idle", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        tick(); settle();
        chk_out("tag_byte", 1'b1, 8'hF2, 3'b000, 3'b100, 1'b1);
        tick(); settle();
        chk_out("tag_data", 1'b1, 8'hA5, 3'b100, 3'b100, 1'b1);
        tick(); setreq(2, 1'b0, 8'h00, 1'b0); settle();
        chk_out("tag_end", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);

        do_reset();
        setreq(2, 1'b1, 8'hA5, 1'b1);
        tick(); settle();
        chk_out("tagr_byte", 1'b1, 8'hF2, 3'b000, 3'b100, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("tagr_rst", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        setreq(2, 1'b0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("tagr_quiet%0d", i), 32'(tx_valid), 32'd0);
            tick();
        end
`else
        // T1: reset with everyone valid, requester 0 wins first
        setreq(0, 1'b1, 8'h01, 1'b1);
        setreq(1, 1'b1, 8'h02, 1'b1);
        setreq(2, 1'b1, 8'h03, 1'b1);
        tick(); settle();
        chk_out("rst", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        settle();
        chk_out("rel", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        tick(); settle();
        chk_out("arb0", 1'b1, 8'h01, 3'b001, 3'b001, 1'b1);

        // T2: requester 1 three-byte packet
        do_reset();
        setreq(1, 1'b1, 8'h11, 1'b0);
        settle();
        chk_out("t2_idle", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        tick(); settle();
        chk_out("t2_b0", 1'b1, 8'h11, 3'b010, 3'b010, 1'b1);
        tick(); setreq(1, 1'b1, 8'h22, 1'b0); settle();
        chk_out("t2_b1", 1'b1, 8'h22, 3'b010, 3'b010, 1'b1);
        tick(); setreq(1, 1'b1, 8'h33, 1'b1); settle();
        chk_out("t2_b2", 1'b1, 8'h33, 3'b010, 3'b010, 1'b1);
        tick(); setreq(1, 1'b0, 8'h00, 1'b0); settle();
        chk_out("t2_end", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);

        // T3: all requesters streaming 2-byte packets, order 0,1,2,0 with one bubble between
        do_reset();
        for (int k = 0; k < N; k++) bi[k] = 0;
        for (int c = 0; c < 11; c++) begin
            for (int k = 0; k < N; k++) setreq(k, 1'b1, {4'(k), 4'(bi[k])}, bi[k] == 1);
            settle();
            chk($sformatf("t3_gnt%0d", c), 32'(grant),    32'(e_g[c]));
            chk($sformatf("t3_txv%0d", c), 32'(tx_valid), 32'(e_g[c] != 3'b000));
            chk($sformatf("t3_txd%0d", c), 32'(tx_data),  32'(e_dat[c]));
            rdy_seen = req_ready;
            tick();
            for (int k = 0; k < N; k++) if (rdy_seen[k]) bi[k] = bi[k] ^ 1;
        end

        // T4: tx_ready toggling during requester 2's packet
        do_reset();
        setreq(2, 1'b1, 8'hA1, 1'b0);
        tick();
        for (int s = 0; s < 5; s++) begin
            tx_ready = t4_rdy[s];
            setreq(2, 1'b1, t4_dat[s], t4_dat[s] == 8'hA3);
            settle();
            chk($sformatf("t4_rdy%0d", s), 32'(req_ready), 32'({t4_rdy[s], 2'b00}));
            chk($sformatf("t4_txd%0d", s), 32'(tx_data),   32'(t4_dat[s]));
            chk($sformatf("t4_gnt%0d", s), 32'(grant),     32'd4);
            tick();
        end
        setreq(2, 1'b0, 8'h00, 1'b0);
        tx_ready = 1'b1;
        settle();
        chk_out("t4_end", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);

        // T5: owner stalls mid-packet while requester 1 waits
        do_reset();
        setreq(0, 1'b1, 8'hB0, 1'b0);
        setreq(1, 1'b1, 8'hC0, 1'b1);
        tick(); settle();
        chk_out("t5_b0", 1'b1, 8'hB0, 3'b001, 3'b001, 1'b1);
        tick();
        setreq(0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_out($sformatf("t5_stall%0d", i), 1'b0, 8'h00, 3'b001, 3'b001, 1'b1);
            tick();
        end
        setreq(0, 1'b1, 8'hB1, 1'b1);
        settle();
        chk_out("t5_b1", 1'b1, 8'hB1, 3'b001, 3'b001, 1'b1);
        tick();
        setreq(0, 1'b0, 8'h00, 1'b0);
        settle();
        chk_out("t5_idle", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        tick(); settle();
        chk_out("t5_r1", 1'b1, 8'hC0, 3'b010, 3'b010, 1'b1);

        // T6: reset mid-packet drops the line at once
        do_reset();
        tx_ready = 1'b0;
        setreq(2, 1'b1, 8'hA5, 1'b1);
        tick(); settle();
        chk_out("t6_gnt", 1'b1, 8'hA5, 3'b000, 3'b100, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst", 1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
        tick();
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
